inst_encoder: RTL and testbench
===============================

# inst_encoder

Sequential LA32R instruction encoder: the write-side counterpart of the CPU's instruction decoder. It accepts field-level instruction requests (operation, register indices, byte-level immediate) over a valid/ready handshake, packs them into 32-bit LA32R machine words, range-checks the immediates, and streams the words into instruction memory at consecutive addresses. It sits between the test/boot loader and the imem write port, so programs can be built without a host assembler.

## Interface
- ADDR_W, 10, imem word-address width
- BASE_ADDR, 0, first word address written after reset or clr
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous restart: address to BASE_ADDR, count/err/done cleared
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept this cycle
- in_op  in  4  0 ADD.W, 1 SUB.W, 2 ADDI.W, 3 LU12I.W, 4 LD.W, 5 ST.W, 6 BEQ, 7 B, 8 BL, 9 JIRL; 10-15 illegal
- in_rd, in_rj, in_rk  in  5 each  register indices
- in_imm  in  32  signed immediate; byte offset for branches/JIRL
- in_last  in  1  marks final instruction of program
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/clr
- done  out  1  program complete or memory full (sticky)
- err  out  1  sticky: at least one request was illegal
- err_addr  out  ADDR_W  address of first illegal request

## Operation
- Encodings (OR'd with fields): ADD.W 0x00100000, SUB.W 0x00110000 {rk[14:10],rj[9:5],rd[4:0]}; ADDI.W 0x02800000, LD.W 0x28800000, ST.W 0x29800000 {si12=imm[11:0] at [21:10],rj,rd}; LU12I.W 0x14000000 {imm[31:12] at [24:5],rd}; BEQ 0x58000000, JIRL 0x4C000000 {imm[17:2] at [25:10],rj,rd}; B 0x50000000, BL 0x54000000 {imm[17:2] at [25:10], imm[27:18] at [9:0]}.
- Legality: si12 ops need imm in [-2048,2047]; LU12I.W needs imm[11:0]==0; BEQ/JIRL need imm[1:0]==0 and imm in [-2^17, 2^17-4]; B/BL need imm[1:0]==0 and imm in [-2^27, 2^27-4]; op 10-15 illegal. Register fields unchecked.
- Illegal request: still consumes one slot; writes NOP 0x03400000; sets err; err_addr loaded only on first occurrence.
- States: RUN (in_ready=1), DONE (in_ready=0). RUN->DONE when accepted request has in_last=1, or accepted request occupies the last address (2^ADDR_W-1). DONE->RUN only on clr. Address never wraps.
- clr has priority over a same-cycle handshake (request dropped); it also squashes a pending write.

## Timing
- Reset (rstn low, async): state RUN, in_ready=1 after release, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err=0, err_addr=0.
- Handshake: transfer when in_valid && in_ready at rising edge; inputs held by source while valid && !ready.
- Latency 1: request accepted at edge N gives imem_we=1 with addr/wdata during cycle N+1; throughput 1 word/cycle.
- imem_addr increments after each write strobe; count increments same edge as strobe completes.
- done asserts the cycle after the final write strobe (i.e., 2 edges after last accept); in_ready drops the cycle after the last accept.
- Reset asserted mid-write: strobe deasserts immediately (asynchronous).

## Test plan
- ADD.W rd=1,rj=2,rk=3 then in_last ADDI.W rd=4,rj=5,imm=-1 -> writes 0x00100C41 @0, 0x02BFFCA4 @1; done, count=2, err=0.
- LU12I.W rd=1 imm=0x12345000 -> 0x1424 68A1 (0x142468A1); imm=0x12345001 -> 0x03400000 written, err=1, err_addr=0.
- B imm=-4 -> 0x53FFFFFF; BEQ rj=1,rd=2,imm=8 -> 0x58000822; BEQ imm=6 -> NOP, err.
- Continuous in_valid for 2^ADDR_W+3 requests, no in_last -> exactly 2^ADDR_W strobes, done=1, in_ready=0, count=2^ADDR_W.
- Backpressure/clr: clr during handshake cycle -> no strobe, addr=BASE_ADDR, err/done cleared next cycle.
- rstn pulsed low while imem_we high -> imem_we=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Request channel between the program source (loader/bench) and the
// LA32R instruction encoder: one field-level instruction per handshake.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rj;
    logic [4:0]  in_rk;
    logic [31:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_op, in_rd, in_rj, in_rk, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rj, in_rk, in_imm, in_last,
        output in_ready
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs field-level requests into 32-bit LA32R machine words,
// range-checks immediates, and streams the words to instruction memory at
// consecutive word addresses. Illegal requests still take a slot and write
// a NOP, flagging the first offending address.
module inst_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    inst_encoder_if.slave     req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_LU12I = 4'd3;
    localparam logic [3:0] OP_LD    = 4'd4;
    localparam logic [3:0] OP_ST    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_B     = 4'd7;
    localparam logic [3:0] OP_BL    = 4'd8;
    localparam logic [3:0] OP_JIRL  = 4'd9;

    localparam logic [31:0]       NOP_WORD  = 32'h0340_0000;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // True when the immediate is representable for the given operation.
    function automatic logic imm_legal(input logic [3:0] op, input logic [31:0] imm);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB:
                ok = 1'b1;
            OP_ADDI, OP_LD, OP_ST:
                ok = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
            OP_LU12I:
                ok = (imm[11:0] == 12'h000);
            OP_BEQ, OP_JIRL:
                ok = (imm[1:0] == 2'b00) && ((&imm[31:17]) || !(|imm[31:17]));
            OP_B, OP_BL:
                ok = (imm[1:0] == 2'b00) && ((&imm[31:27]) || !(|imm[31:27]));
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Field packing for each supported operation; unknown ops map to NOP.
    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rj, input logic [4:0] rk,
                                           input logic [31:0] imm);
        logic [31:0] w;
        w = NOP_WORD;
        case (op)
            OP_ADD:   w = 32'h0010_0000 | {17'd0, rk, rj, rd};
            OP_SUB:   w = 32'h0011_0000 | {17'd0, rk, rj, rd};
            OP_ADDI:  w = 32'h0280_0000 | {10'd0, imm[11:0], rj, rd};
            OP_LD:    w = 32'h2880_0000 | {10'd0, imm[11:0], rj, rd};
            OP_ST:    w = 32'h2980_0000 | {10'd0, imm[11:0], rj, rd};
            OP_LU12I: w = 32'h1400_0000 | {7'd0, imm[31:12], rd};
            OP_BEQ:   w = 32'h5800_0000 | {6'd0, imm[17:2], rj, rd};
            OP_JIRL:  w = 32'h4C00_0000 | {6'd0, imm[17:2], rj, rd};
            OP_B:     w = 32'h5000_0000 | {6'd0, imm[17:2], imm[27:18]};
            OP_BL:    w = 32'h5400_0000 | {6'd0, imm[17:2], imm[27:18]};
            default:  w = NOP_WORD;
        endcase
        return w;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic                we_r;
    logic                fin_r;      // write in flight is the program's final word
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [ADDR_W:0]     count_r;
    logic                done_r;
    logic                err_r;
    logic [ADDR_W-1:0]   err_addr_r;

    logic                accept_s;
    logic                legal_s;
    logic                final_s;
    logic [ADDR_W-1:0]   slot_s;
    logic [31:0]         word_s;

    assign req.in_ready = (state_r == ST_RUN);
    assign accept_s     = req.in_valid && req.in_ready && !clr;

    // Slot for the request being accepted now: one past the word still on the bus.
    always_comb begin
        slot_s  = addr_r;
        legal_s = imm_legal(req.in_op, req.in_imm);
        word_s  = NOP_WORD;
        if (we_r) begin
            slot_s = addr_r + ADDR_ONE;
        end else begin
            slot_s = addr_r;
        end
        if (legal_s) begin
            word_s = encode(req.in_op, req.in_rd, req.in_rj, req.in_rk, req.in_imm);
        end else begin
            word_s = NOP_WORD;
        end
        final_s = req.in_last || (slot_s == LAST_ADDR);
    end

    // Next-state logic: stop accepting after the final or memory-filling request.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (accept_s && final_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Write datapath, address/count bookkeeping and sticky status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_r       <= 1'b0;
            fin_r      <= 1'b0;
            addr_r     <= BASE_ADDR;
            wdata_r    <= 32'h0000_0000;
            count_r    <= {(ADDR_W+1){1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
        end else if (clr) begin
            we_r       <= 1'b0;
            fin_r      <= 1'b0;
            addr_r     <= BASE_ADDR;
            wdata_r    <= wdata_r;
            count_r    <= {(ADDR_W+1){1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
        end else begin
            we_r  <= accept_s;
            fin_r <= accept_s && final_s;
            if (accept_s) begin
                wdata_r <= word_s;
            end else begin
                wdata_r <= wdata_r;
            end
            if (we_r) begin
                count_r <= count_r + CNT_ONE;
                if (addr_r != LAST_ADDR) begin
                    addr_r <= addr_r + ADDR_ONE;
                end else begin
                    addr_r <= addr_r;
                end
            end else begin
                count_r <= count_r;
                addr_r  <= addr_r;
            end
            if (we_r && fin_r) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
            if (accept_s && !legal_s) begin
                err_r <= 1'b1;
                if (!err_r) begin
                    err_addr_r <= slot_s;
                end else begin
                    err_addr_r <= err_addr_r;
                end
            end else begin
                err_r      <= err_r;
                err_addr_r <= err_addr_r;
            end
        end
    end

    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign count      = count_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_addr   = err_addr_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: the driver pushes the hand-computed
// (address, word) for every accepted request; a negedge monitor pops and
// compares on each write strobe.
module tb_inst_encoder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err;
    logic [AW-1:0] err_addr;

    inst_encoder_if bus();

    inst_encoder #(.ADDR_W(AW), .BASE_ADDR(10'd0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .req        (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [31:0] imm;
        logic        last;
        logic [31:0] word;
        logic        legal;
    } vec_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_strobe = 0;
    logic [AW-1:0] m_addr = '0;
    logic [AW:0]   m_cnt = '0;
    logic          m_err = 1'b0;
    logic [AW-1:0] m_err_addr = '0;

    localparam logic [31:0] NOP = 32'h0340_0000;

    vec_t prog1[2] = '{
        '{4'd0, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h0010_0C41, 1'b1},
        '{4'd2, 5'd4, 5'd5, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h02BF_FCA4, 1'b1}
    };

    vec_t prog2[16] = '{
        '{4'd3,  5'd1,  5'd0,  5'd0,  32'h1234_5000, 1'b0, 32'h1424_68A1, 1'b1},
        '{4'd3,  5'd1,  5'd0,  5'd0,  32'h1234_5001, 1'b0, NOP,           1'b0},
        '{4'd7,  5'd0,  5'd0,  5'd0,  32'hFFFF_FFFC, 1'b0, 32'h53FF_FFFF, 1'b1},
        '{4'd6,  5'd2,  5'd1,  5'd0,  32'h0000_0008, 1'b0, 32'h5800_0822, 1'b1},
        '{4'd6,  5'd2,  5'd1,  5'd0,  32'h0000_0006, 1'b0, NOP,           1'b0},
        '{4'd12, 5'd1,  5'd1,  5'd1,  32'h0000_0000, 1'b0, NOP,           1'b0},
        '{4'd2,  5'd0,  5'd0,  5'd0,  32'h0000_0800, 1'b0, NOP,           1'b0},
        '{4'd2,  5'd0,  5'd0,  5'd0,  32'hFFFF_F800, 1'b0, 32'h02A0_0000, 1'b1},
        '{4'd9,  5'd1,  5'd1,  5'd0,  32'h0000_0000, 1'b0, 32'h4C00_0021, 1'b1},
        '{4'd8,  5'd0,  5'd0,  5'd0,  32'h07FF_FFFC, 1'b0, 32'h57FF_FDFF, 1'b1},
        '{4'd8,  5'd0,  5'd0,  5'd0,  32'h0800_0000, 1'b0, NOP,           1'b0},
        '{4'd4,  5'd3,  5'd4,  5'd0,  32'h0000_0010, 1'b0, 32'h2880_4083, 1'b1},
        '{4'd5,  5'd7,  5'd8,  5'd0,  32'hFFFF_FFF8, 1'b0, 32'h29BF_E107, 1'b1},
        '{4'd1,  5'd31, 5'd30, 5'd29, 32'h0000_0000, 1'b0, 32'h0011_77DF, 1'b1},
        '{4'd6,  5'd0,  5'd0,  5'd0,  32'hFFFE_0000, 1'b0, 32'h5A00_0000, 1'b1},
        '{4'd6,  5'd0,  5'd0,  5'd0,  32'h0002_0000, 1'b1, NOP,           1'b0}
    };

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_strobe++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe: unexpected write addr 0x%0h data 0x%0h", imem_addr, imem_wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("write", {imem_addr, imem_wdata}, {mon_e.addr, mon_e.data});
            end
        end
    end

    task automatic set_fields(input vec_t v);
        bus.in_op   = v.op;
        bus.in_rd   = v.rd;
        bus.in_rj   = v.rj;
        bus.in_rk   = v.rk;
        bus.in_imm  = v.imm;
        bus.in_last = v.last;
    endtask

    task automatic send(input vec_t v);
        int w;
        @(negedge clk);
        set_fields(v);
        bus.in_valid = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept: in_ready stayed %b, required 1", bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            sb.push_back('{m_addr, v.word});
            if (!v.legal) begin
                if (!m_err) m_err_addr = m_addr;
                m_err = 1'b1;
            end
            m_addr = m_addr + 10'd1;
            m_cnt  = m_cnt + 11'd1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic model_clear();
        m_addr     = '0;
        m_cnt      = '0;
        m_err      = 1'b0;
        m_err_addr = '0;
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_we"},      imem_we,     1'b0);
        chk({tag, "_addr"},    imem_addr,   m_addr);
        chk({tag, "_count"},   count,       m_cnt);
        chk({tag, "_done"},    done,        1'b0);
        chk({tag, "_err"},     err,         1'b0);
        chk({tag, "_erraddr"}, err_addr,    10'd0);
        chk({tag, "_ready"},   bus.in_ready, 1'b1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        check_idle_state("clr");
    endtask

    // Safety net in case a handshake never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int s0;
        bus.in_valid = 1'b0;
        bus.in_op    = 4'd0;
        bus.in_rd    = 5'd0;
        bus.in_rj    = 5'd0;
        bus.in_rk    = 5'd0;
        bus.in_imm   = 32'd0;
        bus.in_last  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wdata", imem_wdata, 32'd0);
        check_idle_state("rst");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_idle_state("rel");

        // Two-word program ending with in_last
        for (int i = 0; i < 2; i++) send(prog1[i]);
        chk("p1_ready_drop", bus.in_ready, 1'b0);
        chk("p1_done_early", done, 1'b0);
        idle();
        @(posedge clk);
        #1;
        chk("p1_done",  done,      1'b1);
        chk("p1_count", count,     11'd2);
        chk("p1_err",   err,       1'b0);
        chk("p1_addr",  imem_addr, 10'd2);
        do_clr();

        // Encodings and immediate legality, back to back
        for (int i = 0; i < 16; i++) send(prog2[i]);
        idle();
        @(posedge clk);
        #1;
        chk("p2_done",    done,     1'b1);
        chk("p2_err",     err,      m_err);
        chk("p2_erraddr", err_addr, m_err_addr);
        chk("p2_count",   count,    m_cnt);
        do_clr();

        // clr beats a same-cycle handshake and discards in-flight bookkeeping
        v = prog2[5];
        send(v);
        v = prog1[0];
        send(v);
        @(negedge clk);
        set_fields(prog1[0]);
        bus.in_valid = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        check_idle_state("sq");
        @(posedge clk);
        #1;
        chk("sq_no_strobe", imem_we, 1'b0);

        // Asynchronous reset while a write strobe is high
        send(prog2[5]);
        send(prog1[0]);
        @(negedge clk);
        set_fields(prog1[1]);
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("ar_we_before", imem_we, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        model_clear();
        chk("ar_wdata", imem_wdata, 32'd0);
        check_idle_state("ar");
        @(negedge clk);
        rstn = 1'b1;

        // Continuous stream past the end of memory
        s0 = n_strobe;
        for (int i = 0; i < (1 << AW) + 3; i++) begin
            logic [9:0] iv;
            iv = i[9:0];
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_op    = 4'd0;
            bus.in_rd    = iv[4:0];
            bus.in_rj    = iv[9:5];
            bus.in_rk    = 5'd0;
            bus.in_imm   = 32'd0;
            bus.in_last  = 1'b0;
            chk("fill_ready", bus.in_ready, (i < (1 << AW)) ? 1'b1 : 1'b0);
            if (i < (1 << AW)) begin
                sb.push_back('{iv, 32'h0010_0000 | {22'd0, iv[9:5], iv[4:0]}});
            end
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("fill_strobes", n_strobe - s0, 1024);
        chk("fill_done",    done,          1'b1);
        chk("fill_ready_f", bus.in_ready,  1'b0);
        chk("fill_count",   count,         11'd1024);
        chk("fill_addr",    imem_addr,     10'd1023);
        chk("sb_drained",   sb.size(),     0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
